// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode classification for the multi-cycle ALU.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b000001;
  localparam logic [5:0] ALU_SUB   = 6'b000010;
  localparam logic [5:0] ALU_SLL   = 6'b000011;
  localparam logic [5:0] ALU_SLT   = 6'b000100;
  localparam logic [5:0] ALU_OR    = 6'b000101;
  localparam logic [5:0] ALU_XOR   = 6'b000110;
  localparam logic [5:0] ALU_SGT   = 6'b000111;
  localparam logic [5:0] ALU_AND   = 6'b001000;
  localparam logic [5:0] ALU_SRL   = 6'b001001;
  localparam logic [5:0] ALU_SRA   = 6'b001010;
  localparam logic [5:0] ALU_SLTU  = 6'b001011;
  localparam logic [5:0] ALU_MUL   = 6'b010000;
  localparam logic [5:0] ALU_MULHU = 6'b010001;
  localparam logic [5:0] ALU_DIVU  = 6'b010010;
  localparam logic [5:0] ALU_REMU  = 6'b010011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_t;

  // The four iterative opcodes share the 0100xx prefix.
  function automatic logic is_iterative(input logic [5:0] op);
    return op[5:2] == 4'b0100;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add multiply or restoring divide, one step per enabled cycle.
module alu_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            i_start,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_step,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic            r_div;

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_diff;

  // o_hi/o_lo present the pair as it will be after the current step.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_sh   = {r_hi, r_lo[XLEN-1]};
    w_diff = w_sh - {1'b0, r_b};
    if (r_div) begin
      if (w_diff[XLEN]) begin
        o_hi = w_sh[XLEN-1:0];
        o_lo = {r_lo[XLEN-2:0], 1'b0};
      end else begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {r_lo[XLEN-2:0], 1'b1};
      end
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // No reset: a start always reloads every register before it is used.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_div <= i_div;
    end else if (i_step) begin
      r_hi <= o_hi;
      r_lo <= o_lo;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops plus iterative mul/div.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      alu_control,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(XLEN - 1);

  alu_state_t      r_state;
  alu_state_t      w_state_nxt;
  logic [SHW:0]    r_cnt;
  logic            r_hi_sel;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sc_res;
  logic            w_sc_ill;
  logic            w_iter;
  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;

  assign w_shamt  = src2[SHW-1:0];
  assign w_iter   = is_iterative(alu_control);
  assign w_accept = (r_state == IDLE) && in_valid && !flush;
  assign w_step   = (r_state == BUSY) && !flush;
  assign w_last   = (r_cnt == CNT_LAST);

  always_comb begin
    w_sc_res = '0;
    w_sc_ill = 1'b0;
    case (alu_control)
      ALU_ADD:  w_sc_res = src1 + src2;
      ALU_SUB:  w_sc_res = src1 - src2;
      ALU_SLL:  w_sc_res = src1 << w_shamt;
      ALU_SLT:  w_sc_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_OR:   w_sc_res = src1 | src2;
      ALU_XOR:  w_sc_res = src1 ^ src2;
      ALU_SGT:  w_sc_res = {{(XLEN-1){1'b0}}, ($signed(src1) > $signed(src2))};
      ALU_AND:  w_sc_res = src1 & src2;
      ALU_SRL:  w_sc_res = src1 >> w_shamt;
      ALU_SRA:  w_sc_res = $signed(src1) >>> w_shamt;
      ALU_SLTU: w_sc_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      default:  w_sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_nxt = w_iter ? BUSY : DONE;
        BUSY:    if (w_last) w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_hi_sel    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_cnt    <= '0;
        r_hi_sel <= alu_control[0];
        if (!w_iter) begin
          r_result  <= w_sc_res;
          r_illegal <= w_sc_ill;
        end
      end
      if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          // MULHU and REMU take the high half; MUL and DIVU the low half.
          r_result  <= r_hi_sel ? w_hi : w_lo;
          r_illegal <= 1'b0;
          r_cnt     <= '0;
        end
      end
    end
  end

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk    (clk),
    .i_start(w_accept && w_iter),
    .i_div  (alu_control[1]),
    .i_a    (src1),
    .i_b    (src2),
    .i_step (w_step),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign illegal   = r_illegal;

endmodule
